// File: rtl/shot_sequencer_if.sv
// Handshake and data bundle between the shot sequencer and the kinematic
// trajectory unit. The sequencer is the master: it loads velocity and
// requests steps; the kinematic unit answers with a pixel position.
interface shot_sequencer_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int VW = 12
);
    logic                 kin_load;
    logic                 kin_step;
    logic signed [VW-1:0] kin_vx;
    logic signed [VW-1:0] kin_vy;
    logic                 kin_done;
    logic        [XW-1:0] kin_x;
    logic        [YW-1:0] kin_y;

    modport master (
        output kin_load, kin_step, kin_vx, kin_vy,
        input  kin_done, kin_x, kin_y
    );

    modport slave (
        input  kin_load, kin_step, kin_vx, kin_vy,
        output kin_done, kin_x, kin_y
    );
endinterface

// File: rtl/shot_sequencer.sv
// Sequences one basketball shot through the kinematic trajectory unit:
// load launch velocity, step once per frame tick, then judge each new
// position against the hoop window and the screen bounds.
// Optional build macro SHOT_STATS_EN adds saturating shots_taken and
// shots_made counters; without it both outputs are tied to zero.
module shot_sequencer #(
    parameter int XW          = 10,
    parameter int YW          = 10,
    parameter int VW          = 12,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int HOOP_X_MIN  = 500,
    parameter int HOOP_X_MAX  = 540,
    parameter int HOOP_Y      = 200,
    parameter int MAX_FRAMES  = 255,
    parameter int KIN_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 launch,
    input  logic signed [VW-1:0] launch_vx,
    input  logic signed [VW-1:0] launch_vy,
    shot_sequencer_if.master     kin,
    output logic        [XW-1:0] ball_x,
    output logic        [YW-1:0] ball_y,
    output logic                 busy,
    output logic                 made,
    output logic                 missed,
    output logic                 overrun,
    output logic                 timeout,
    output logic        [7:0]    frame_cnt,
    output logic        [7:0]    shots_made,
    output logic        [7:0]    shots_taken
);
    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_TICK, STEP, WAIT_DONE, CHECK, RESULT
    } state_t;

    localparam int WDW = $clog2(KIN_TIMEOUT + 1);

    localparam logic [XW-1:0]  X_OFF    = XW'(SCREEN_W);
    localparam logic [YW-1:0]  Y_OFF    = YW'(SCREEN_H);
    localparam logic [YW-1:0]  Y_START  = YW'(SCREEN_H - 1);
    localparam logic [XW-1:0]  HOOP_XL  = XW'(HOOP_X_MIN);
    localparam logic [XW-1:0]  HOOP_XR  = XW'(HOOP_X_MAX);
    localparam logic [YW-1:0]  RIM_Y    = YW'(HOOP_Y);
    localparam logic [7:0]     FRAME_LIM = 8'(MAX_FRAMES);
    // wd counts WAIT_DONE cycles from 0; together with the STEP cycle and the
    // registered flag, timeout rises exactly KIN_TIMEOUT cycles after kin_step.
    localparam logic [WDW-1:0] WD_LAST  = WDW'(KIN_TIMEOUT - 2);

    state_t         state, next_state;
    logic [YW-1:0]  prev_y;
    logic [WDW-1:0] wd;
    logic           accept, hit, miss, wd_expired;
    logic           scored, out_of_play;

    // Ball falls through the rim plane inside the hoop window.
    assign scored = (prev_y < RIM_Y) && (ball_y >= RIM_Y) &&
                    (ball_x >= HOOP_XL) && (ball_x <= HOOP_XR);
    assign out_of_play = (ball_x >= X_OFF) || (ball_y >= Y_OFF) ||
                         (frame_cnt == FRAME_LIM);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and Moore-style strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        next_state   = state;
        kin.kin_load = 1'b0;
        kin.kin_step = 1'b0;
        busy         = 1'b1;
        accept       = 1'b0;
        hit          = 1'b0;
        miss         = 1'b0;
        wd_expired   = 1'b0;
        case (state)
            IDLE, RESULT: begin
                busy = 1'b0;
                if (launch) begin
                    accept     = 1'b1;
                    next_state = INIT;
                end
            end
            INIT: begin
                kin.kin_load = 1'b1;
                next_state   = WAIT_TICK;
            end
            WAIT_TICK: if (frame_tick) next_state = STEP;
            STEP: begin
                kin.kin_step = 1'b1;
                next_state   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (kin.kin_done) begin
                    next_state = CHECK;
                end else if (wd == WD_LAST) begin
                    wd_expired = 1'b1;
                    next_state = RESULT;
                end
            end
            CHECK: begin
                if (scored) begin
                    hit        = 1'b1;
                    next_state = RESULT;
                end else if (out_of_play) begin
                    miss       = 1'b1;
                    next_state = RESULT;
                end else begin
                    next_state = WAIT_TICK;
                end
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Launch capture and per-step frame counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kin.kin_vx <= '0;
            kin.kin_vy <= '0;
            frame_cnt  <= '0;
        end else if (accept) begin
            kin.kin_vx <= launch_vx;
            kin.kin_vy <= launch_vy;
            frame_cnt  <= '0;
        end else if (state == STEP && frame_cnt != 8'hFF) begin
            frame_cnt  <= frame_cnt + 8'd1;
        end
    end

    // Ball position for the renderer and the y before the latest step.
    // prev_y advances only when a shot continues, so during CHECK it always
    // holds the pre-step height (SCREEN_H-1 on the first step of a shot).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x <= '0;
            ball_y <= '0;
            prev_y <= '0;
        end else begin
            if (state == INIT) prev_y <= Y_START;
            if (state == WAIT_DONE && kin.kin_done) begin
                ball_x <= kin.kin_x;
                ball_y <= kin.kin_y;
            end
            if (state == CHECK && next_state == WAIT_TICK) prev_y <= ball_y;
        end
    end

    // Watchdog on the kinematic unit's response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   wd <= '0;
        else if (state == STEP)      wd <= '0;
        else if (state == WAIT_DONE) wd <= wd + 1'b1;
    end

    // Result and sticky status flags, cleared by an accepted launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            made    <= 1'b0;
            missed  <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else if (accept) begin
            made    <= 1'b0;
            missed  <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (hit)                    made    <= 1'b1;
            if (miss || wd_expired)     missed  <= 1'b1;
            if (wd_expired)             timeout <= 1'b1;
            if (frame_tick && (state inside {INIT, STEP, WAIT_DONE, CHECK}))
                overrun <= 1'b1;
        end
    end

`ifdef SHOT_STATS_EN
    // Lifetime shot statistics, saturating, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shots_taken <= '0;
            shots_made  <= '0;
        end else begin
            if (accept && shots_taken != 8'hFF) shots_taken <= shots_taken + 8'd1;
            if (hit && shots_made != 8'hFF)     shots_made  <= shots_made + 8'd1;
        end
    end
`else
    assign shots_taken = '0;
    assign shots_made  = '0;
`endif
endmodule
